// File: rtl/riscv_rf_pkg.sv
// Shared types and elaboration helpers for the multi-port register file.
// Contents:
//   rf_state_e      scrub sequencer state
//   rf_num_words    words per bank for a given address width
//   rf_num_tot      total words (integer bank plus optional FP bank)
//   rf_ports_ok     legal read/write port-count range
package riscv_rf_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    localparam int unsigned RF_MIN_PORTS = 1;
    localparam int unsigned RF_MAX_READ  = 4;
    localparam int unsigned RF_MAX_WRITE = 3;

    // One bank holds half the address space; the address MSB picks the bank.
    function automatic int unsigned rf_num_words(input int unsigned addr_width);
        return 32'd1 << (addr_width - 32'd1);
    endfunction

    function automatic int unsigned rf_num_tot(input int unsigned addr_width,
                                               input int unsigned fpu);
        return (fpu != 0) ? 2 * rf_num_words(addr_width) : rf_num_words(addr_width);
    endfunction

    function automatic bit rf_ports_ok(input int unsigned n_read,
                                       input int unsigned n_write);
        return (n_read  >= RF_MIN_PORTS) && (n_read  <= RF_MAX_READ) &&
               (n_write >= RF_MIN_PORTS) && (n_write <= RF_MAX_WRITE);
    endfunction

endpackage

// File: rtl/riscv_register_file_mp_if.sv
// Register-file access bus between the ID stage and the register file.
// Signals:
//   raddr_i / rdata_o   N_READ combinational read ports
//   waddr_i / wdata_i / we_i   N_WRITE writeback ports
//   clear_i             one-cycle scrub request
//   ready_o             1 = register file idle, writes accepted
// Modports: master (pipeline side), slave (register file side).
interface riscv_register_file_mp_if #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N_READ     = 3,
    parameter int unsigned N_WRITE    = 2
);

    logic [N_READ-1:0][ADDR_WIDTH-1:0]  raddr_i;
    logic [N_READ-1:0][DATA_WIDTH-1:0]  rdata_o;
    logic [N_WRITE-1:0][ADDR_WIDTH-1:0] waddr_i;
    logic [N_WRITE-1:0][DATA_WIDTH-1:0] wdata_i;
    logic [N_WRITE-1:0]                 we_i;
    logic                               clear_i;
    logic                               ready_o;

    modport master (
        output raddr_i, waddr_i, wdata_i, we_i, clear_i,
        input  rdata_o, ready_o
    );

    modport slave (
        input  raddr_i, waddr_i, wdata_i, we_i, clear_i,
        output rdata_o, ready_o
    );

endinterface

// File: rtl/riscv_rf_clear_seq.sv
// Scrub sequencer: after reset or a clear request, walks every flat word
// index once, one per cycle, then reports ready.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_clear        scrub request (honoured only when ready)
//   o_clr_we       scrub write strobe for word o_clr_addr
//   o_clr_addr     flat word index being zeroed
//   o_ready        1 = idle (state flop)
module riscv_rf_clear_seq
    import riscv_rf_pkg::*;
#(
    parameter int unsigned NUM_TOT = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_clear,
    output logic                       o_clr_we,
    output logic [$clog2(NUM_TOT)-1:0] o_clr_addr,
    output logic                       o_ready
);

    localparam int unsigned CNT_W = $clog2(NUM_TOT);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_TOT - 1);

    rf_state_e        r_state;
    rf_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RF_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: a clear request while scrubbing is dropped, not restarted.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            RF_CLEAR: begin
                if (r_cnt == LAST_IDX) begin
                    w_state_nxt = RF_READY;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RF_READY: begin
                if (i_clear) begin
                    w_state_nxt = RF_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
        endcase
    end

    assign o_clr_we   = (r_state == RF_CLEAR);
    assign o_clr_addr = r_cnt;
    assign o_ready    = (r_state == RF_READY);

endmodule

// File: rtl/riscv_register_file_mp.sv
// Multi-port flop register file with optional FP bank, optional
// write-to-read bypass and a self-scrubbing reset sequence.
// Ports:
//   clk, rst_n     core clock, asynchronous active-low reset
//   test_en_i      forces all per-word write clock enables on (scan)
//   bus            slave side of riscv_register_file_mp_if
// Flat word index: integer bank at 0..NUM_WORDS-1, FP bank above it, so with
// an FP bank the flat index equals the address; without one the MSB is dropped.
module riscv_register_file_mp
    import riscv_rf_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FPU        = 0,
    parameter int unsigned N_READ     = 3,
    parameter int unsigned N_WRITE    = 2,
    parameter int unsigned BYPASS     = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     test_en_i,
    riscv_register_file_mp_if.slave  bus
);

    localparam int unsigned NUM_TOT = rf_num_tot(ADDR_WIDTH, FPU);
    localparam int unsigned FLAT_W  = $clog2(NUM_TOT);

    if (!rf_ports_ok(N_READ, N_WRITE)) begin : g_bad_ports
        $error("riscv_register_file_mp: N_READ must be 1..4 and N_WRITE 1..3");
    end

    logic                  w_clr_we;
    logic [FLAT_W-1:0]     w_clr_addr;
    logic                  w_ready;

    logic [FLAT_W-1:0]     w_wflat [N_WRITE];
    logic [N_WRITE-1:0]    w_wvalid;
    logic [NUM_TOT-1:0]    w_word_en;
    logic [NUM_TOT-1:0]    w_gate_en;
    logic [DATA_WIDTH-1:0] w_word_d [NUM_TOT];
    logic [DATA_WIDTH-1:0] r_mem    [NUM_TOT];

    logic [FLAT_W-1:0]     w_rflat  [N_READ];
    logic [DATA_WIDTH-1:0] w_rdata  [N_READ];
    logic                  w_raddr_unused;

    riscv_rf_clear_seq #(
        .NUM_TOT (NUM_TOT)
    ) u_clear_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (bus.clear_i),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr),
        .o_ready    (w_ready)
    );

    // Write qualification: only while ready, never integer x0, and the FP
    // half of the address space is discarded when there is no FP bank.
    always_comb begin
        for (int unsigned p = 0; p < N_WRITE; p++) begin
            w_wflat[p]  = FLAT_W'(bus.waddr_i[p]);
            w_wvalid[p] = w_ready && bus.we_i[p] && (w_wflat[p] != '0) &&
                          ((FPU != 0) || !bus.waddr_i[p][ADDR_WIDTH-1]);
        end
    end

    // Per-word decode; later (higher-index) ports override earlier ones.
    always_comb begin
        w_word_en = '0;
        for (int unsigned k = 0; k < NUM_TOT; k++) begin
            w_word_d[k] = '0;
        end
        for (int unsigned k = 0; k < NUM_TOT; k++) begin
            if (w_clr_we && (w_clr_addr == FLAT_W'(k))) begin
                w_word_en[k] = 1'b1;
            end
            for (int unsigned p = 0; p < N_WRITE; p++) begin
                if (w_wvalid[p] && (w_wflat[p] == FLAT_W'(k))) begin
                    w_word_en[k] = 1'b1;
                    w_word_d[k]  = bus.wdata_i[p];
                end
            end
        end
    end

    // Clock-gate enables; scan mode opens every gate (contents not functional then).
    assign w_gate_en = w_word_en | {NUM_TOT{test_en_i}};

    // Storage: no reset, contents are defined by the scrub sequence.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < NUM_TOT; k++) begin
            if (w_gate_en[k]) begin
                r_mem[k] <= w_word_d[k];
            end
        end
    end

    // Read muxes with optional same-cycle forwarding; zero while scrubbing.
    always_comb begin
        for (int unsigned r = 0; r < N_READ; r++) begin
            w_rflat[r] = FLAT_W'(bus.raddr_i[r]);
            w_rdata[r] = (w_rflat[r] == '0) ? '0 : r_mem[w_rflat[r]];
            if (BYPASS != 0) begin
                for (int unsigned p = 0; p < N_WRITE; p++) begin
                    if (w_wvalid[p] && (w_wflat[p] == w_rflat[r])) begin
                        w_rdata[r] = bus.wdata_i[p];
                    end
                end
            end
            bus.rdata_o[r] = w_ready ? w_rdata[r] : '0;
        end
    end

    // Read-address MSB is dropped when there is no FP bank.
    assign w_raddr_unused = ^bus.raddr_i;

    assign bus.ready_o = w_ready;

endmodule

// File: tb/tb_riscv_register_file_mp.sv
// Bench: one FPU=1/BYPASS=1 and one FPU=0/BYPASS=0 instance, reference model
// plus read scoreboard.
module tb_riscv_register_file_mp;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 3;
    localparam int unsigned NW = 2;
    localparam int NT_FP  = 64;
    localparam int NT_INT = 32;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic test_en = 1'b0;

    always #5 clk = ~clk;

    riscv_register_file_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_READ(NR), .N_WRITE(NW)) bus_fp ();
    riscv_register_file_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_READ(NR), .N_WRITE(NW)) bus_int ();

    riscv_register_file_mp #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FPU(1), .N_READ(NR), .N_WRITE(NW), .BYPASS(1)
    ) u_dut_fp (
        .clk(clk), .rst_n(rst_n), .test_en_i(test_en), .bus(bus_fp)
    );

    riscv_register_file_mp #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FPU(0), .N_READ(NR), .N_WRITE(NW), .BYPASS(0)
    ) u_dut_int (
        .clk(clk), .rst_n(rst_n), .test_en_i(test_en), .bus(bus_int)
    );

    typedef struct {
        bit          fp;
        int          port;
        logic [5:0]  addr;
        logic [31:0] exp;
    } rd_exp_t;

    typedef struct {
        bit          fp;
        int          port;
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_t;

    rd_exp_t     sb[$];
    wr_t         pend[$];
    logic [31:0] m_fp  [NT_FP];
    logic [31:0] m_int [NT_INT];
    int          left_fp;
    int          left_int;
    bit          clr_fp;
    bit          clr_int;
    string       phase;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected read value this cycle, including FP-instance forwarding.
    function automatic logic [31:0] model_rd(input bit fp, input logic [5:0] a);
        logic [31:0] v;
        if (fp) begin
            if (left_fp > 0) return '0;
            v = (a == 6'd0) ? 32'd0 : m_fp[a];
            for (int p = 0; p < int'(NW); p++)
                foreach (pend[i])
                    if (pend[i].fp && pend[i].port == p && pend[i].addr == a && a != 6'd0)
                        v = pend[i].data;
        end else begin
            if (left_int > 0) return '0;
            v = (a[4:0] == 5'd0) ? 32'd0 : m_int[a[4:0]];
        end
        return v;
    endfunction

    task automatic model_edge(input bit fp);
        if (fp) begin
            if (left_fp > 0) left_fp--;
            else if (clr_fp) begin
                left_fp = NT_FP;
                foreach (m_fp[i]) m_fp[i] = '0;
            end else
                for (int p = 0; p < int'(NW); p++)
                    foreach (pend[i])
                        if (pend[i].fp && pend[i].port == p && pend[i].addr != 6'd0)
                            m_fp[pend[i].addr] = pend[i].data;
        end else begin
            if (left_int > 0) left_int--;
            else if (clr_int) begin
                left_int = NT_INT;
                foreach (m_int[i]) m_int[i] = '0;
            end else
                for (int p = 0; p < int'(NW); p++)
                    foreach (pend[i])
                        if (!pend[i].fp && pend[i].port == p && !pend[i].addr[5] &&
                            pend[i].addr[4:0] != 5'd0)
                            m_int[pend[i].addr[4:0]] = pend[i].data;
        end
    endtask

    task automatic wr(input bit fp, input int port, input logic [5:0] a, input logic [31:0] d);
        wr_t w;
        w.fp = fp; w.port = port; w.addr = a; w.data = d;
        pend.push_back(w);
        if (fp) begin
            bus_fp.we_i[port] = 1'b1; bus_fp.waddr_i[port] = a; bus_fp.wdata_i[port] = d;
        end else begin
            bus_int.we_i[port] = 1'b1; bus_int.waddr_i[port] = a; bus_int.wdata_i[port] = d;
        end
    endtask

    task automatic rd(input bit fp, input int port, input logic [5:0] a);
        rd_exp_t e;
        e.fp = fp; e.port = port; e.addr = a; e.exp = model_rd(fp, a);
        sb.push_back(e);
        if (fp) bus_fp.raddr_i[port] = a;
        else    bus_int.raddr_i[port] = a;
    endtask

    task automatic pulse_clear(input bit fp);
        if (fp) begin bus_fp.clear_i = 1'b1;  clr_fp = 1'b1;  end
        else    begin bus_int.clear_i = 1'b1; clr_int = 1'b1; end
    endtask

    // Compare at negedge, advance one clock edge, release single-cycle inputs.
    task automatic step();
        rd_exp_t     e;
        logic [31:0] got;
        @(negedge clk);
        check($sformatf("%s_ready_fp", phase),  32'(bus_fp.ready_o),  32'(left_fp == 0));
        check($sformatf("%s_ready_int", phase), 32'(bus_int.ready_o), 32'(left_int == 0));
        while (sb.size() != 0) begin
            e   = sb.pop_front();
            got = e.fp ? bus_fp.rdata_o[e.port] : bus_int.rdata_o[e.port];
            check($sformatf("%s_%s_p%0d_a%0d", phase, e.fp ? "fp" : "int", e.port, e.addr),
                  got, e.exp);
        end
        @(posedge clk);
        if (rst_n) begin
            model_edge(1'b1);
            model_edge(1'b0);
        end
        #1;
        bus_fp.we_i  = '0; bus_int.we_i  = '0;
        bus_fp.clear_i = 1'b0; bus_int.clear_i = 1'b0;
        clr_fp = 1'b0; clr_int = 1'b0;
        pend.delete();
    endtask

    // Asynchronous reset for one cycle, released just after a rising edge.
    task automatic do_reset();
        rst_n    = 1'b0;
        left_fp  = NT_FP;
        left_int = NT_INT;
        foreach (m_fp[i])  m_fp[i]  = '0;
        foreach (m_int[i]) m_int[i] = '0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic rand_reads();
        for (int p = 0; p < int'(NR); p++) begin
            rd(1'b1, p, 6'($urandom_range(0, 63)));
            rd(1'b0, p, 6'($urandom_range(0, 63)));
        end
    endtask

    task automatic rand_cycles(input int n);
        logic [5:0] a;
        for (int c = 0; c < n; c++) begin
            for (int b = 0; b < 2; b++)
                for (int p = 0; p < int'(NW); p++)
                    if ($urandom_range(0, 1) == 1) begin
                        a = 6'($urandom_range(0, 15));
                        if ($urandom_range(0, 2) == 0) a[5] = 1'b1;
                        wr(b == 0, p, a, $urandom());
                    end
            for (int p = 0; p < int'(NR); p++) begin
                a = 6'($urandom_range(0, 15));
                if ($urandom_range(0, 2) == 0) a[5] = 1'b1;
                rd(1'b1, p, a);
                rd(1'b0, p, 6'($urandom_range(0, 63)));
            end
            step();
        end
    endtask

    initial begin
        bus_fp.raddr_i = '0; bus_fp.waddr_i = '0; bus_fp.wdata_i = '0;
        bus_fp.we_i = '0; bus_fp.clear_i = 1'b0;
        bus_int.raddr_i = '0; bus_int.waddr_i = '0; bus_int.wdata_i = '0;
        bus_int.we_i = '0; bus_int.clear_i = 1'b0;
        clr_fp = 1'b0; clr_int = 1'b0;

        phase = "reset";
        do_reset();

        // Power-up scrub: reads forced to 0, ready after exactly NUM_TOT edges.
        phase = "scrub0";
        for (int c = 0; c < 70; c++) begin
            rand_reads();
            step();
        end

        phase = "zero";
        for (int a = 1; a < 64; a += 3) begin
            for (int p = 0; p < int'(NR); p++)
                if (a + p < 64) rd(1'b1, p, 6'(a + p));
            step();
        end

        phase = "wr5";
        wr(1'b1, 0, 6'd5, 32'hDEADBEEF); wr(1'b0, 0, 6'd5, 32'hDEADBEEF);
        rd(1'b1, 0, 6'd5); rd(1'b0, 0, 6'd5);
        step();
        rd(1'b1, 0, 6'd5); rd(1'b0, 0, 6'd5);
        step();

        phase = "x0";
        wr(1'b1, 0, 6'd0, 32'h1234); wr(1'b0, 0, 6'd0, 32'h1234);
        rd(1'b1, 0, 6'd0); rd(1'b0, 0, 6'd0);
        step();
        rd(1'b1, 0, 6'd0); rd(1'b0, 0, 6'd0);
        step();

        phase = "coll";
        wr(1'b1, 0, 6'd7, 32'h11); wr(1'b1, 1, 6'd7, 32'h22);
        wr(1'b0, 0, 6'd7, 32'h11); wr(1'b0, 1, 6'd7, 32'h22);
        rd(1'b1, 0, 6'd7); rd(1'b0, 0, 6'd7);
        step();
        rd(1'b1, 1, 6'd7); rd(1'b0, 1, 6'd7);
        step();

        phase = "coll_rev";
        wr(1'b1, 1, 6'd41, 32'h4242); wr(1'b1, 0, 6'd41, 32'h4141);
        rd(1'b1, 2, 6'd41);
        step();
        rd(1'b1, 2, 6'd41);
        step();

        phase = "fpbank";
        wr(1'b1, 0, 6'd32, 32'hA5A5A5A5);
        step();
        rd(1'b1, 0, 6'd32); rd(1'b1, 1, 6'd0);
        step();

        phase = "msb";
        wr(1'b0, 0, 6'd8, 32'h88);
        step();
        wr(1'b0, 1, 6'd40, 32'h40);
        rd(1'b0, 0, 6'd40);
        step();
        rd(1'b0, 0, 6'd8); rd(1'b0, 1, 6'd40);
        step();

        phase = "rand1";
        rand_cycles(40);

        phase = "fill";
        for (int a = 1; a < 64; a += 2) begin
            wr(1'b1, 0, 6'(a), $urandom());
            if (a + 1 < 64) wr(1'b1, 1, 6'(a + 1), $urandom());
            if (a < 32) wr(1'b0, 0, 6'(a), $urandom());
            step();
        end

        // Clear with a same-cycle write: performed, forwarded, then scrubbed.
        phase = "clr";
        wr(1'b1, 0, 6'd9, 32'h99);
        pulse_clear(1'b1);
        rd(1'b1, 0, 6'd9);
        step();
        for (int c = 0; c < 70; c++) begin
            if (c == 20) pulse_clear(1'b1);
            if (left_fp > 0) wr(1'b1, 0, 6'd3, 32'hFFFF0000 | 32'(c));
            rand_reads();
            step();
        end
        phase = "clr_zero";
        for (int a = 0; a < 64; a += 3) begin
            for (int p = 0; p < int'(NR); p++)
                if (a + p < 64) rd(1'b1, p, 6'(a + p));
            step();
        end

        // Reset at scrub cycle 10, then a second clear that must not extend.
        phase = "rst_mid";
        pulse_clear(1'b1); pulse_clear(1'b0);
        step();
        for (int c = 0; c < 10; c++) begin
            rand_reads();
            step();
        end
        do_reset();
        for (int c = 0; c < 70; c++) begin
            if (c == 20) begin pulse_clear(1'b1); pulse_clear(1'b0); end
            rand_reads();
            step();
        end

        phase = "rand2";
        rand_cycles(30);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
